// File: rtl/wt_dcache_rd_missunit.sv
// Read-miss responder for the write-through L1 dcache: one outstanding miss,
// memory fetch, optional refill of the chosen way, then a single word return.
module wt_dcache_rd_missunit #(
  parameter int unsigned DCACHE_SET_ASSOC    = 8,
  parameter int unsigned DCACHE_LINE_WIDTH   = 128,
  parameter int unsigned DCACHE_TAG_WIDTH    = 52,
  parameter int unsigned DCACHE_CL_IDX_WIDTH = 8,
  parameter int unsigned DCACHE_OFFSET_WIDTH = 4,
  parameter int unsigned CACHE_ID_WIDTH      = 4,
  parameter logic [7:0]  LfsrSeed            = 8'hFF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           miss_req_i,
  output logic                           miss_ack_o,
  output logic                           miss_replay_o,
  input  logic [63:0]                    miss_paddr_i,
  input  logic [2:0]                     miss_size_i,
  input  logic                           miss_nc_i,
  input  logic                           miss_approx_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_i,
  input  logic [CACHE_ID_WIDTH-1:0]      miss_id_i,
  output logic                           miss_rtrn_vld_o,
  output logic [63:0]                    rtrn_data_o,
  input  logic                           wr_idx_busy_i,
  output logic                           mem_data_req_o,
  input  logic                           mem_data_ack_i,
  output logic [63:0]                    mem_paddr_o,
  output logic [2:0]                     mem_size_o,
  output logic                           mem_nc_o,
  output logic                           mem_approx_o,
  output logic [CACHE_ID_WIDTH-1:0]      mem_id_o,
  input  logic                           mem_rtrn_vld_i,
  input  logic [CACHE_ID_WIDTH-1:0]      mem_rtrn_id_i,
  input  logic [DCACHE_LINE_WIDTH-1:0]   mem_rtrn_data_i,
  output logic                           wr_cl_vld_o,
  input  logic                           wr_cl_ack_i,
  output logic [DCACHE_TAG_WIDTH-1:0]    wr_cl_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] wr_cl_idx_o,
  output logic [DCACHE_SET_ASSOC-1:0]    wr_cl_way_oh_o,
  output logic [DCACHE_LINE_WIDTH-1:0]   wr_cl_data_o
);

  localparam int unsigned WAY_W = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1;

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, REFILL, RTRN} state_e;

  state_e                         state_q, state_d;
  logic [7:0]                     lfsr_q, lfsr_d;
  logic [63:0]                    paddr_q, paddr_d;
  logic [2:0]                     size_q, size_d;
  logic                           nc_q, nc_d;
  logic                           approx_q, approx_d;
  logic [CACHE_ID_WIDTH-1:0]      id_q, id_d;
  logic [DCACHE_SET_ASSOC-1:0]    way_oh_q, way_oh_d;
  logic [DCACHE_LINE_WIDTH-1:0]   line_q, line_d;
  logic [DCACHE_SET_ASSOC-1:0]    inv_oh, rnd_oh;
  logic                           all_vld;

  // Gated with reset so nothing leaks out while the block is held in reset.
  assign miss_ack_o    = rst_ni & (state_q == IDLE) & miss_req_i & ~wr_idx_busy_i;
  assign miss_replay_o = rst_ni & (state_q == IDLE) & miss_req_i &  wr_idx_busy_i;
  assign all_vld       = &miss_vld_bits_i;

  always_comb begin
    inv_oh = '0;
    for (int i = DCACHE_SET_ASSOC - 1; i >= 0; i--) begin
      if (!miss_vld_bits_i[i]) begin
        inv_oh    = '0;
        inv_oh[i] = 1'b1;
      end
    end
    rnd_oh = '0;
    rnd_oh[lfsr_q[WAY_W-1:0]] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    paddr_d  = paddr_q;
    size_d   = size_q;
    nc_d     = nc_q;
    approx_d = approx_q;
    id_d     = id_q;
    way_oh_d = way_oh_q;
    line_d   = line_q;
    case (state_q)
      IDLE: begin
        if (miss_ack_o) begin
          paddr_d  = miss_paddr_i;
          size_d   = miss_nc_i ? miss_size_i : 3'b111;
          nc_d     = miss_nc_i;
          approx_d = miss_approx_i;
          id_d     = miss_id_i;
          way_oh_d = miss_nc_i ? '0 : (all_vld ? rnd_oh : inv_oh);
          // The LFSR only moves when it actually picks the victim.
          if (!miss_nc_i && all_vld)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          state_d = MEM_REQ;
        end
      end
      MEM_REQ:  if (mem_data_ack_i) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (mem_rtrn_vld_i && mem_rtrn_id_i == id_q) begin
          line_d  = mem_rtrn_data_i;
          state_d = nc_q ? RTRN : REFILL;
        end
      end
      REFILL:   if (wr_cl_ack_i) state_d = RTRN;
      RTRN:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      lfsr_q   <= LfsrSeed;
      paddr_q  <= '0;
      size_q   <= '0;
      nc_q     <= 1'b0;
      approx_q <= 1'b0;
      id_q     <= '0;
      way_oh_q <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      paddr_q  <= paddr_d;
      size_q   <= size_d;
      nc_q     <= nc_d;
      approx_q <= approx_d;
      id_q     <= id_d;
      way_oh_q <= way_oh_d;
      line_q   <= line_d;
    end
  end

  assign mem_data_req_o  = (state_q == MEM_REQ);
  assign mem_paddr_o     = nc_q ? paddr_q
                                : {paddr_q[63:DCACHE_OFFSET_WIDTH], {DCACHE_OFFSET_WIDTH{1'b0}}};
  assign mem_size_o      = size_q;
  assign mem_nc_o        = nc_q;
  assign mem_approx_o    = approx_q;
  assign mem_id_o        = id_q;

  assign wr_cl_vld_o     = (state_q == REFILL);
  assign wr_cl_tag_o     = paddr_q[DCACHE_OFFSET_WIDTH+DCACHE_CL_IDX_WIDTH +: DCACHE_TAG_WIDTH];
  assign wr_cl_idx_o     = paddr_q[DCACHE_OFFSET_WIDTH +: DCACHE_CL_IDX_WIDTH];
  assign wr_cl_way_oh_o  = way_oh_q;
  assign wr_cl_data_o    = line_q;

  // NC data arrives right-aligned, so only cacheable lines need word selection.
  assign miss_rtrn_vld_o = (state_q == RTRN);
  assign rtrn_data_o     = nc_q ? line_q[63:0]
                                : line_q[{paddr_q[DCACHE_OFFSET_WIDTH-1:3], 6'b0} +: 64];

endmodule

// File: tb/tb_wt_dcache_rd_missunit.sv
// Directed and randomized checks of the dcache read-miss unit against a
// transaction-level reference model (way choice, LFSR sequence, addresses, data).
module tb_wt_dcache_rd_missunit;
  localparam int WAYS = 8, LW = 128, TW = 52, IW = 8, OW = 4, IDW = 4;

  logic            clk_i = 1'b0, rst_ni = 1'b0;
  logic            miss_req_i = 1'b0, miss_ack_o, miss_replay_o;
  logic [63:0]     miss_paddr_i = '0;
  logic [2:0]      miss_size_i = '0;
  logic            miss_nc_i = 1'b0, miss_approx_i = 1'b0;
  logic [WAYS-1:0] miss_vld_bits_i = '0;
  logic [IDW-1:0]  miss_id_i = '0;
  logic            miss_rtrn_vld_o;
  logic [63:0]     rtrn_data_o;
  logic            wr_idx_busy_i = 1'b0;
  logic            mem_data_req_o, mem_data_ack_i = 1'b0;
  logic [63:0]     mem_paddr_o;
  logic [2:0]      mem_size_o;
  logic            mem_nc_o, mem_approx_o;
  logic [IDW-1:0]  mem_id_o;
  logic            mem_rtrn_vld_i = 1'b0;
  logic [IDW-1:0]  mem_rtrn_id_i = '0;
  logic [LW-1:0]   mem_rtrn_data_i = '0;
  logic            wr_cl_vld_o, wr_cl_ack_i = 1'b0;
  logic [TW-1:0]   wr_cl_tag_o;
  logic [IW-1:0]   wr_cl_idx_o;
  logic [WAYS-1:0] wr_cl_way_oh_o;
  logic [LW-1:0]   wr_cl_data_o;

  wt_dcache_rd_missunit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .miss_req_i(miss_req_i), .miss_ack_o(miss_ack_o), .miss_replay_o(miss_replay_o),
    .miss_paddr_i(miss_paddr_i), .miss_size_i(miss_size_i), .miss_nc_i(miss_nc_i),
    .miss_approx_i(miss_approx_i), .miss_vld_bits_i(miss_vld_bits_i), .miss_id_i(miss_id_i),
    .miss_rtrn_vld_o(miss_rtrn_vld_o), .rtrn_data_o(rtrn_data_o),
    .wr_idx_busy_i(wr_idx_busy_i),
    .mem_data_req_o(mem_data_req_o), .mem_data_ack_i(mem_data_ack_i),
    .mem_paddr_o(mem_paddr_o), .mem_size_o(mem_size_o), .mem_nc_o(mem_nc_o),
    .mem_approx_o(mem_approx_o), .mem_id_o(mem_id_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_id_i(mem_rtrn_id_i), .mem_rtrn_data_i(mem_rtrn_data_i),
    .wr_cl_vld_o(wr_cl_vld_o), .wr_cl_ack_i(wr_cl_ack_i), .wr_cl_tag_o(wr_cl_tag_o),
    .wr_cl_idx_o(wr_cl_idx_o), .wr_cl_way_oh_o(wr_cl_way_oh_o), .wr_cl_data_o(wr_cl_data_o)
  );

  always #5 clk_i = ~clk_i;

  int         errors = 0, checks = 0;
  logic [7:0] lfsr_m;

  // Reference replacement sequence: 8-bit Fibonacci LFSR with taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  function automatic logic any_out();
    return |{miss_ack_o, miss_replay_o, miss_rtrn_vld_o, rtrn_data_o, mem_data_req_o,
             mem_paddr_o, mem_size_o, mem_nc_o, mem_approx_o, mem_id_o, wr_cl_vld_o,
             wr_cl_tag_o, wr_cl_idx_o, wr_cl_way_oh_o, wr_cl_data_o};
  endfunction

  task automatic do_miss(input logic [63:0] pa, input logic [2:0] sz, input logic nc,
                         input logic ap, input logic [WAYS-1:0] vld, input logic [IDW-1:0] id,
                         input logic [LW-1:0] line, input int mdly, input bit foreign,
                         input int wdly);
    logic [WAYS-1:0] exp_oh;
    logic [63:0]     exp_pa, exp_word;
    logic [2:0]      exp_sz;
    bit              found;
    exp_oh = '0;
    found  = 0;
    if (!nc) begin
      if (&vld) begin
        exp_oh[lfsr_m[2:0]] = 1'b1;
        lfsr_m = lfsr_step(lfsr_m);
      end else begin
        for (int i = 0; i < WAYS; i++)
          if (!vld[i] && !found) begin exp_oh[i] = 1'b1; found = 1; end
      end
    end
    exp_pa   = nc ? pa : (pa & ~64'hF);
    exp_sz   = nc ? sz : 3'b111;
    exp_word = nc ? line[63:0] : (pa[3] ? line[127:64] : line[63:0]);

    step();
    miss_req_i = 1; miss_paddr_i = pa; miss_size_i = sz; miss_nc_i = nc;
    miss_approx_i = ap; miss_vld_bits_i = vld; miss_id_i = id; wr_idx_busy_i = 0;
    #1;
    chk("ack", miss_ack_o, 1);
    chk("no_replay", miss_replay_o, 0);
    step();
    miss_req_i = 0; miss_paddr_i = '0; miss_vld_bits_i = '0;
    #1;
    for (int k = 0; k < mdly; k++) begin
      chk("mem_req_hold", mem_data_req_o, 1);
      chk("mem_paddr_hold", mem_paddr_o, exp_pa);
      step(); #1;
    end
    mem_data_ack_i = 1;
    chk("mem_req", mem_data_req_o, 1);
    chk("mem_paddr", mem_paddr_o, exp_pa);
    chk("mem_size", mem_size_o, exp_sz);
    chk("mem_nc", mem_nc_o, nc);
    chk("mem_approx", mem_approx_o, ap);
    chk("mem_id", mem_id_o, id);
    step();
    mem_data_ack_i = 0;
    #1;
    chk("mem_req_drop", mem_data_req_o, 0);
    if (foreign) begin
      mem_rtrn_vld_i = 1; mem_rtrn_id_i = id ^ 4'h1; mem_rtrn_data_i = ~line;
      step();
      mem_rtrn_vld_i = 0;
      #1;
      chk("foreign_no_wr", wr_cl_vld_o, 0);
      chk("foreign_no_rtrn", miss_rtrn_vld_o, 0);
    end
    mem_rtrn_vld_i = 1; mem_rtrn_id_i = id; mem_rtrn_data_i = line;
    step();
    mem_rtrn_vld_i = 0; mem_rtrn_data_i = '0;
    #1;
    if (!nc) begin
      chk("wr_vld", wr_cl_vld_o, 1);
      chk("wr_tag", wr_cl_tag_o, pa[63:12]);
      chk("wr_idx", wr_cl_idx_o, pa[11:4]);
      chk("wr_way", wr_cl_way_oh_o, exp_oh);
      chk("wr_data", wr_cl_data_o, line);
      chk("rtrn_early", miss_rtrn_vld_o, 0);
      for (int k = 0; k < wdly; k++) begin
        step(); #1;
        chk("wr_vld_hold", wr_cl_vld_o, 1);
        chk("wr_way_hold", wr_cl_way_oh_o, exp_oh);
      end
      wr_cl_ack_i = 1;
      step();
      wr_cl_ack_i = 0;
    end else begin
      chk("nc_no_wr", wr_cl_vld_o, 0);
    end
    miss_req_i = 1; wr_idx_busy_i = 0;
    #1;
    chk("rtrn_vld", miss_rtrn_vld_o, 1);
    chk("rtrn_data", rtrn_data_o, exp_word);
    chk("wr_vld_drop", wr_cl_vld_o, 0);
    chk("busy_no_ack", miss_ack_o, 0);
    chk("busy_no_replay", miss_replay_o, 0);
    step();
    miss_req_i = 0;
    #1;
    chk("rtrn_pulse", miss_rtrn_vld_o, 0);
  endtask

  initial begin
    lfsr_m = 8'hFF;
    #2;
    chk("reset_outs", any_out(), 0);
    step(); step();
    #1 rst_ni = 1;

    // Directed cacheable miss: way 3 is the only invalid one, word 1 returned.
    do_miss(64'h8000_1238, 3'b011, 0, 0, 8'b1111_0111, 4'h5,
            {64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF}, 0, 0, 0);
    // Directed NC miss.
    do_miss(64'h1000_0004, 3'b010, 1, 1, 8'h00, 4'h2,
            {64'hAAAA_BBBB_CCCC_DDDD, 64'h1122_3344_5566_7788}, 1, 0, 1);

    // Replay while the write port is busy on the index.
    step();
    miss_req_i = 1; wr_idx_busy_i = 1; miss_paddr_i = 64'h8000_2000;
    #1;
    chk("replay", miss_replay_o, 1);
    chk("replay_no_ack", miss_ack_o, 0);
    step();
    miss_req_i = 0; wr_idx_busy_i = 0;
    #1;
    chk("replay_pulse", miss_replay_o, 0);
    chk("replay_no_mem", mem_data_req_o, 0);
    step();
    chk("replay_no_mem2", mem_data_req_o, 0);

    // All ways valid three times, then an invalid-way miss, then all-valid again.
    do_miss(64'h8000_3000, 3'b111, 0, 0, 8'hFF, 4'h1, {2{64'h1111_0000_0000_0001}}, 0, 0, 0);
    do_miss(64'h8000_3048, 3'b111, 0, 0, 8'hFF, 4'h3, {2{64'h2222_0000_0000_0002}}, 2, 0, 1);
    do_miss(64'h8000_3090, 3'b111, 0, 0, 8'hFF, 4'h7, {2{64'h3333_0000_0000_0003}}, 0, 0, 0);
    do_miss(64'h8000_4008, 3'b111, 0, 0, 8'b1110_1111, 4'h8, {64'h4, 64'h5}, 0, 0, 0);
    do_miss(64'h8000_5000, 3'b111, 0, 0, 8'hFF, 4'h9, {64'h6, 64'h7}, 0, 0, 0);

    // Foreign-ID return ignored.
    do_miss(64'h8000_6018, 3'b111, 0, 0, 8'h0F, 4'hA, {64'hCAFE, 64'hF00D}, 0, 1, 0);

    // Reset while waiting on memory.
    step();
    miss_req_i = 1; miss_paddr_i = 64'h8000_7000; miss_id_i = 4'hC; miss_vld_bits_i = 8'h00;
    #1;
    chk("pre_rst_ack", miss_ack_o, 1);
    step();
    miss_req_i = 0; mem_data_ack_i = 1;
    step();
    mem_data_ack_i = 0;
    #1;
    rst_ni = 0;
    #1;
    chk("midrst_outs", any_out(), 0);
    lfsr_m = 8'hFF;
    step();
    rst_ni = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_no_rtrn", miss_rtrn_vld_o, 0);
      chk("post_rst_no_mem", mem_data_req_o, 0);
    end
    do_miss(64'h8000_7008, 3'b111, 0, 0, 8'hFF, 4'hC, {64'h77, 64'h88}, 0, 0, 0);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      logic [63:0]     pa;
      logic [WAYS-1:0] vld;
      logic            nc;
      pa  = {$urandom, $urandom};
      nc  = ($urandom_range(0, 3) == 0);
      vld = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      do_miss(pa, 3'($urandom), nc, 1'($urandom), vld, 4'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
              1'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
